// File: rtl/dm_cache_fsm_pkg.sv
// Shared types and geometry for the direct-mapped cache: 1024 lines of 128-bit blocks, 18-bit tags.
// Latency: none (types only). Backpressure: none.
package cache_def;

  localparam int TAGMSB = 31;
  localparam int TAGLSB = 14;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    COMPARE_TAG = 2'd1,
    ALLOCATE    = 2'd2,
    WRITE_BACK  = 2'd3
  } cache_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        rw;
    logic        valid;
  } cpu_req_type;

  typedef struct packed {
    logic [31:0] data;
    logic        ready;
  } cpu_result_type;

  typedef struct packed {
    logic [31:0]  addr;
    logic [127:0] data;
    logic         rw;
    logic         valid;
  } mem_req_type;

  typedef struct packed {
    logic [127:0] data;
    logic         ready;
  } mem_data_type;

  typedef struct packed {
    logic                 valid;
    logic                 dirty;
    logic [TAGMSB:TAGLSB] tag;
  } cache_tag_type;

  typedef struct packed {
    logic [9:0] index;
    logic       we;
  } cache_req_type;

  typedef logic [127:0] cache_data_type;

endpackage

// File: rtl/dm_cache_store.sv
// Tag and data arrays; reads are combinational, writes land on the clock edge.
// Latency: 0-cycle read, 1-cycle write. Backpressure: none. Only valid/dirty bits are reset.
module dm_cache_store
  import cache_def::*;
(
  input  logic           clk,
  input  logic           rst,
  input  cache_req_type  tag_req,
  input  cache_tag_type  tag_write,
  output cache_tag_type  tag_read,
  input  cache_req_type  data_req,
  input  cache_data_type data_write,
  output cache_data_type data_read
);

  logic [1023:0]        valid_bits;
  logic [1023:0]        dirty_bits;
  logic [TAGMSB:TAGLSB] tag_mem  [1024];
  cache_data_type       data_mem [1024];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_bits <= '0;
      dirty_bits <= '0;
    end else if (tag_req.we) begin
      valid_bits[tag_req.index] <= tag_write.valid;
      dirty_bits[tag_req.index] <= tag_write.dirty;
    end
  end

  always_ff @(posedge clk) begin
    if (tag_req.we) tag_mem[tag_req.index] <= tag_write.tag;
  end

  always_ff @(posedge clk) begin
    if (data_req.we) data_mem[data_req.index] <= data_write;
  end

  assign tag_read  = '{valid: valid_bits[tag_req.index],
                       dirty: dirty_bits[tag_req.index],
                       tag:   tag_mem[tag_req.index]};
  assign data_read = data_mem[data_req.index];

endmodule

// File: rtl/dm_cache_fsm.sv
// Direct-mapped write-back cache controller; DM_CACHE_PERF_EN adds hit/miss counters.
// Latency: hit ready one cycle after IDLE accepts; misses wait on mem_data.ready, CPU holds cpu_req until cpu_res.ready.
module dm_cache_fsm
  import cache_def::*;
(
  input  logic           clk,
  input  logic           rst,
  input  cpu_req_type    cpu_req,
  input  mem_data_type   mem_data,
  output mem_req_type    mem_req,
  output cpu_result_type cpu_res
`ifdef DM_CACHE_PERF_EN
  ,
  output logic [31:0]    hit_cnt,
  output logic [31:0]    miss_cnt
`endif
);

  cache_state_t         state;
  logic [TAGMSB:TAGLSB] victim_tag;

  cache_req_type  tag_req;
  cache_req_type  data_req;
  cache_tag_type  tag_write;
  cache_tag_type  tag_read;
  cache_data_type data_write;
  cache_data_type data_read;

  logic [9:0]           index;
  logic [TAGMSB:TAGLSB] req_tag;
  logic [1:0]           word;
  logic                 hit;

  assign index   = cpu_req.addr[13:4];
  assign req_tag = cpu_req.addr[TAGMSB:TAGLSB];
  assign word    = cpu_req.addr[3:2];
  assign hit     = (state == COMPARE_TAG) && tag_read.valid && (tag_read.tag == req_tag);

  always_comb begin
    mem_req    = '0;
    cpu_res    = '0;
    tag_req    = '{index: index, we: 1'b0};
    data_req   = '{index: index, we: 1'b0};
    tag_write  = '{valid: 1'b1, dirty: cpu_req.rw, tag: req_tag};
    data_write = data_read;
    case (state)
      COMPARE_TAG: begin
        if (hit) begin
          cpu_res.ready = 1'b1;
          if (cpu_req.rw) begin
            data_write[32*word +: 32] = cpu_req.data;
            data_req.we     = 1'b1;
            tag_req.we      = 1'b1;
            tag_write.dirty = 1'b1;
          end else begin
            cpu_res.data = data_read[32*word +: 32];
          end
        end else begin
          // The tag is claimed now; the victim tag survives in victim_tag for write-back.
          tag_req.we    = 1'b1;
          mem_req.valid = 1'b1;
        end
      end
      WRITE_BACK: begin
        mem_req.addr  = {victim_tag, index, 4'b0000};
        mem_req.data  = data_read;
        mem_req.rw    = 1'b1;
        mem_req.valid = 1'b1;
      end
      ALLOCATE: begin
        mem_req.addr  = cpu_req.addr;
        mem_req.valid = 1'b1;
        if (mem_data.ready) begin
          data_write  = mem_data.data;
          data_req.we = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      victim_tag <= '0;
    end else begin
      case (state)
        IDLE:        if (cpu_req.valid) state <= COMPARE_TAG;
        COMPARE_TAG: begin
          if (hit) begin
            state <= IDLE;
          end else begin
            victim_tag <= tag_read.tag;
            state      <= (tag_read.valid && tag_read.dirty) ? WRITE_BACK : ALLOCATE;
          end
        end
        WRITE_BACK:  if (mem_data.ready) state <= ALLOCATE;
        ALLOCATE:    if (mem_data.ready) state <= COMPARE_TAG;
        default:     state <= IDLE;
      endcase
    end
  end

`ifdef DM_CACHE_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state == COMPARE_TAG) begin
      if (hit) hit_cnt  <= hit_cnt + 32'd1;
      else     miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

  dm_cache_store u_store (
    .clk       (clk),
    .rst       (rst),
    .tag_req   (tag_req),
    .tag_write (tag_write),
    .tag_read  (tag_read),
    .data_req  (data_req),
    .data_write(data_write),
    .data_read (data_read)
  );

endmodule

// File: tb/tb_dm_cache_fsm.sv
// Bench for dm_cache_fsm: directed sequence then random conflicting traffic against a line-level cache model.
module tb_dm_cache_fsm;
  import cache_def::*;

  logic           clk;
  logic           rst;
  cpu_req_type    cpu_req;
  mem_data_type   mem_data;
  mem_req_type    mem_req;
  cpu_result_type cpu_res;

  dm_cache_fsm dut (
    .clk     (clk),
    .rst     (rst),
    .cpu_req (cpu_req),
    .mem_data(mem_data),
    .mem_req (mem_req),
    .cpu_res (cpu_res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: per-line state plus a backing memory keyed by block address.
  bit           mv   [1024];
  bit           md   [1024];
  logic [17:0]  mtag [1024];
  logic [127:0] mdat [1024];
  logic [127:0] mem  [logic [27:0]];

  task automatic check_eq(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] mem_get(input logic [27:0] b);
    if (mem.exists(b)) return mem[b];
    return {4'h1, b, 4'h2, b, 4'h3, b, 4'h4, b};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 1024; i++) begin
      mv[i] = 1'b0;
      md[i] = 1'b0;
    end
  endtask

  // Issues one request, acts as memory, checks every cycle; abort pulls reset once ALLOCATE is seen.
  task automatic do_req(input logic [31:0] a, input logic rw, input logic [31:0] wd, input bit abort);
    logic [9:0]     idx;
    logic [17:0]    tg;
    int             w;
    bit             hit;
    mem_req_type    ops [2];
    logic [127:0]   rblk [2];
    int             nops;
    logic [31:0]    exp_rd;
    int             n, opi, wcnt, exp_n;
    bit             busy, done;
    mem_req_type    ann;
    cpu_result_type exp_res;

    idx  = a[13:4];
    tg   = a[31:14];
    w    = int'(a[3:2]);
    hit  = mv[idx] && (mtag[idx] == tg);
    nops = 0;
    if (!hit) begin
      if (mv[idx] && md[idx]) begin
        ops[0]  = '{addr: {mtag[idx], idx, 4'b0000}, data: mdat[idx], rw: 1'b1, valid: 1'b1};
        rblk[0] = '0;
        mem[{mtag[idx], idx}] = mdat[idx];
        nops = 1;
      end
      ops[nops]  = '{addr: a, data: 128'd0, rw: 1'b0, valid: 1'b1};
      rblk[nops] = mem_get(a[31:4]);
      mdat[idx]  = rblk[nops];
      mtag[idx]  = tg;
      mv[idx]    = 1'b1;
      md[idx]    = 1'b0;
      nops++;
    end
    exp_rd = mdat[idx][32*w +: 32];
    if (rw) begin
      mdat[idx][32*w +: 32] = wd;
      md[idx] = 1'b1;
    end
    exp_res = '{data: rw ? 32'd0 : exp_rd, ready: 1'b1};
    ann     = '{addr: 32'd0, data: 128'd0, rw: 1'b0, valid: 1'b1};

    @(negedge clk);
    mem_data = '0;
    cpu_req  = '{addr: a, data: wd, rw: rw, valid: 1'b1};
    n = 0; opi = 0; wcnt = 0; busy = 1'b0; done = 1'b0;
    exp_n = hit ? 1 : 2;
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
      mem_data.ready = 1'b0;
      if (n == 1 && !hit) begin
        check_eq("miss_mem_req", 192'(mem_req), 192'(ann));
        check_eq("miss_cpu_res", 192'(cpu_res), 192'd0);
        // Memory ready outside WRITE_BACK/ALLOCATE must be ignored.
        mem_data = '{data: {$urandom, $urandom, $urandom, $urandom}, ready: 1'($urandom_range(0, 1))};
        continue;
      end
      if (cpu_res.ready) begin
        done = 1'b1;
        check_eq("cpu_res", 192'(cpu_res), 192'(exp_res));
        check_eq("mem_req_on_ready", 192'(mem_req), 192'd0);
        check_eq("mem_ops_done", 192'(opi), 192'(nops));
        check_eq("latency", 192'(n), 192'(exp_n));
        cpu_req.valid = 1'b0;
      end else if (mem_req.valid) begin
        if (!busy) begin
          if (opi < nops) check_eq("mem_req", 192'(mem_req), 192'(ops[opi]));
          else            check_eq("mem_extra", 192'(opi), 192'(nops));
          if (abort && !mem_req.rw) begin
            rst = 1'b0;
            #1;
            check_eq("rst_mem_req", 192'(mem_req), 192'd0);
            check_eq("rst_cpu_res", 192'(cpu_res), 192'd0);
            cpu_req.valid = 1'b0;
            mem_data = '0;
            model_reset();
            done = 1'b1;
            continue;
          end
          busy  = 1'b1;
          wcnt  = $urandom_range(0, 3);
          exp_n = exp_n + wcnt + 1;
        end
        if (wcnt == 0) begin
          mem_data.ready = 1'b1;
          mem_data.data  = (opi < nops && !ops[opi].rw) ? rblk[opi] : {$urandom, $urandom, $urandom, $urandom};
          opi++;
          busy = 1'b0;
        end else begin
          wcnt--;
        end
      end
    end
    check_eq("timeout", 192'(done), 192'd1);
    if (abort) begin
      repeat (2) @(negedge clk);
      check_eq("rst_hold_mem_req", 192'(mem_req), 192'd0);
      check_eq("rst_hold_cpu_res", 192'(cpu_res), 192'd0);
      rst = 1'b1;
    end
  endtask

  task automatic idle_gap();
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      mem_data = '{data: {$urandom, $urandom, $urandom, $urandom}, ready: 1'($urandom_range(0, 1))};
    end
  endtask

  initial begin
    logic [17:0] rt;
    logic [9:0]  ri;
    int          r;

    rst      = 1'b0;
    cpu_req  = '0;
    mem_data = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_eq("reset_mem_req", 192'(mem_req), 192'd0);
    check_eq("reset_cpu_res", 192'(cpu_res), 192'd0);
    rst = 1'b1;

    do_req(32'h0000_0010, 1'b0, 32'd0, 1'b0);
    do_req(32'h0000_0010, 1'b0, 32'd0, 1'b0);
    do_req(32'h0000_0014, 1'b1, 32'hDEAD_BEEF, 1'b0);
    do_req(32'h0000_0014, 1'b0, 32'd0, 1'b0);
    do_req(32'h0000_4010, 1'b0, 32'd0, 1'b0);
    do_req(32'h0000_8010, 1'b0, 32'd0, 1'b1);
    do_req(32'h0000_0010, 1'b0, 32'd0, 1'b0);

    for (int k = 0; k < 300; k++) begin
      idle_gap();
      r  = $urandom_range(0, 3);
      ri = (r == 3) ? 10'd1023 : 10'(r);
      rt = 18'($urandom_range(0, 2));
      do_req({rt, ri, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))},
             1'($urandom_range(0, 1)), $urandom, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
